sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Pixel-colour source feeding the VGA timing stage. It is given the active-area pixel coordinate each clock and returns a 12-bit colour for that pixel two cycles later.
- Draws up to NUM_OBJ axis-aligned square objects over a constant background. The physics engine supplies object positions.
- Position updates arrive through a valid/ready port into a pending bank. They are copied to the active bank only at frame start, so no frame ever shows a half-updated scene.

Parameters:
NUM_OBJ, 4, number of object slots (1..16)
OBJ_SIZE, 32, object edge length in pixels (1..255)
BG_COLOR, 12'h000, background {R,G,B} nibbles
H_ACTIVE, 1600, active columns
V_ACTIVE, 1200, active rows

Ports:
clock_162  in  1  pixel clock, 162 MHz
rst  in  1  synchronous, active-high reset
pix_col  in  12  active-area column, 0..H_ACTIVE-1
pix_row  in  11  active-area row, 0..V_ACTIVE-1
pix_valid  in  1  current coordinate is in the visible area
frame_start  in  1  one-cycle pulse, first clock of a new frame (before row 0 is displayed)
upd_valid  in  1  update request
upd_ready  out  1  update accepted when valid & ready
upd_idx  in  4  object slot
upd_en  in  1  object visible
upd_x  in  12  left column of object
upd_y  in  11  top row of object
upd_color  in  12  object {R,G,B}
red, green, blue  out  4 each  pixel colour
out_valid  out  1  pix_valid delayed by 2
frame_count  out  16  committed frame counter
upd_err  out  1  sticky: an update had upd_idx >= NUM_OBJ

Behaviour:
- Reset (rst high at a clock edge):
  - All pending and active slots get en=0, x=0, y=0, color=0.
  - red/green/blue=0, out_valid=0, frame_count=0, upd_err=0, upd_ready=0.
  - upd_ready rises on the first clock with rst low.
  - Reset mid-frame: all state clears. The pipeline outputs 0 with out_valid=0 for 2 cycles after rst drops.
- Update port:
  - upd_ready=1 in every non-reset cycle except the cycle in which frame_start=1.
  - A transfer occurs on valid & ready. The pending slot upd_idx takes {en,x,y,color} at that edge.
  - Multiple writes to one slot within a frame: last write wins.
  - upd_idx >= NUM_OBJ: the transfer is accepted (ready is not withheld), no slot changes, upd_err sets and holds until reset.
- Commit:
  - On a clock with frame_start=1, every active slot takes its pending value and frame_count increments. frame_count wraps 0xFFFF -> 0.
  - upd_ready is 0 in that cycle, so a write never collides with the commit. The master holds valid and the write completes the next cycle, landing in the following frame.
  - Pending contents are retained after commit; they are not cleared.
- Hit test, pipeline stage 1 (registered):
  - hit[i] = en[i] & (col >= x[i]) & (col <= x[i]+OBJ_SIZE-1) & (row >= y[i]) & (row <= y[i]+OBJ_SIZE-1).
  - Sums are computed one bit wider than the operand, with no wrap-around. Objects extending past H_ACTIVE/V_ACTIVE are clipped simply because those coordinates never arrive.
  - pix_valid, hit vector and colours are registered.
- Colour select, pipeline stage 2 (registered):
  - The lowest-index hit wins on overlap.
  - With no hit, BG_COLOR is output.
  - If the stage-1 pix_valid is 0, the output colour is 0.
  - out_valid = stage-1 pix_valid.
- Latency:
  - Coordinate presented at edge t produces colour at edge t+2.
  - The downstream timing stage delays its sync outputs by 2 cycles to match.
- The hit test uses the active bank only. A commit at a given edge affects coordinates sampled at that edge and after.

Optional Feature:
- Macro: SPRITE_CIRCLE_EN.
- Defined:
  - Each object is the circle inscribed in its square. With r = OBJ_SIZE/2 (integer), dx = col-x-r and dy = row-y-r (signed), a pixel is a hit when it is inside the square AND dx*dx + dy*dy <= r*r.
  - Squares and the compare are computed in stage 1. Latency stays 2.
- Undefined: full-square objects exactly as above, and no multipliers are instantiated.

Test Plan:
- Reset then idle: frame_start pulses, pixel (0,0) valid -> colour = BG_COLOR, frame_count=1, upd_ready=1, upd_err=0.
- Write slot 0 {en=1, x=100, y=50, color=12'hF00} mid-frame -> pixel (110,60) still BG until the next frame_start; after commit, (110,60) = F,0,0 two cycles after input; (131,60) = F,0,0; (132,60) = BG.
- Slots 0 (12'hF00) and 1 (12'h0F0) both at x=200, y=200 -> (210,210) = F,0,0; disable slot 0 and commit -> 0,F,0.
- upd_valid held high, asserted in the same cycle as frame_start -> upd_ready=0 that cycle; the write lands the next cycle and is visible only after the second frame_start.
- upd_idx=15 with NUM_OBJ=4 -> accepted, no slot changes, upd_err=1 held until rst.
- Assert rst mid-frame with slot 0 visible -> all outputs 0 next cycle; after a new frame_start every pixel = BG_COLOR; with SPRITE_CIRCLE_EN, OBJ_SIZE=32, x=y=0: corner (0,0) = BG, centre (16,16) = object colour.

Source files
------------

// File: rtl/sprite_renderer.sv
// Two-stage sprite pixel source: double-buffered object bank, hit test, priority select.
// Optional SPRITE_CIRCLE_EN draws each object as the circle inscribed in its square.
module sprite_renderer #(
  parameter int          NUM_OBJ  = 4,
  parameter int          OBJ_SIZE = 32,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          H_ACTIVE = 1600,
  parameter int          V_ACTIVE = 1200
) (
  input  logic        clock_162,
  input  logic        rst,
  input  logic [11:0] pix_col,
  input  logic [10:0] pix_row,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [3:0]  upd_idx,
  input  logic        upd_en,
  input  logic [11:0] upd_x,
  input  logic [10:0] upd_y,
  input  logic [11:0] upd_color,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        out_valid,
  output logic [15:0] frame_count,
  output logic        upd_err
);

  logic        pend_en [NUM_OBJ];
  logic [11:0] pend_x  [NUM_OBJ];
  logic [10:0] pend_y  [NUM_OBJ];
  logic [11:0] pend_c  [NUM_OBJ];
  logic        act_en  [NUM_OBJ];
  logic [11:0] act_x   [NUM_OBJ];
  logic [10:0] act_y   [NUM_OBJ];
  logic [11:0] act_c   [NUM_OBJ];

  logic               run;
  logic               xfer;
  logic               bad_idx;
  logic               in_area;
  logic [NUM_OBJ-1:0] hit_c;
  logic [NUM_OBJ-1:0] hit1;
  logic [11:0]        eff_c [NUM_OBJ];
  logic [11:0]        col1  [NUM_OBJ];
  logic               v1;
  logic [11:0]        sel;

  assign upd_ready = run & ~frame_start & ~rst;
  assign xfer      = upd_valid & upd_ready;
  assign bad_idx   = {1'b0, upd_idx} >= 5'(NUM_OBJ);
  assign in_area   = (pix_col < 12'(H_ACTIVE)) & (pix_row < 11'(V_ACTIVE));

  always_ff @(posedge clock_162) begin
    if (rst) begin
      run         <= 1'b0;
      frame_count <= 16'd0;
      upd_err     <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        pend_en[i] <= 1'b0;
        pend_x[i]  <= 12'd0;
        pend_y[i]  <= 11'd0;
        pend_c[i]  <= 12'd0;
        act_en[i]  <= 1'b0;
        act_x[i]   <= 12'd0;
        act_y[i]   <= 11'd0;
        act_c[i]   <= 12'd0;
      end
    end else begin
      run <= 1'b1;
      if (xfer && bad_idx) upd_err <= 1'b1;
      if (frame_start) frame_count <= frame_count + 16'd1;
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (xfer && upd_idx == 4'(i)) begin
          pend_en[i] <= upd_en;
          pend_x[i]  <= upd_x;
          pend_y[i]  <= upd_y;
          pend_c[i]  <= upd_color;
        end
        if (frame_start) begin
          act_en[i] <= pend_en[i];
          act_x[i]  <= pend_x[i];
          act_y[i]  <= pend_y[i];
          act_c[i]  <= pend_c[i];
        end
      end
    end
  end

  // A commit edge must already show the new scene, so bypass to pending.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    logic        ee;
    logic [11:0] ex;
    logic [10:0] ey;
    logic [12:0] x_end;
    logic [11:0] y_end;
    logic        in_sq;
    assign ee       = frame_start ? pend_en[g] : act_en[g];
    assign ex       = frame_start ? pend_x[g]  : act_x[g];
    assign ey       = frame_start ? pend_y[g]  : act_y[g];
    assign eff_c[g] = frame_start ? pend_c[g]  : act_c[g];
    assign x_end    = {1'b0, ex} + 13'(OBJ_SIZE - 1);
    assign y_end    = {1'b0, ey} + 12'(OBJ_SIZE - 1);
    assign in_sq    = ee & in_area
                    & ({1'b0, pix_col} >= {1'b0, ex})
                    & ({1'b0, pix_col} <= x_end)
                    & ({1'b0, pix_row} >= {1'b0, ey})
                    & ({1'b0, pix_row} <= y_end);
`ifdef SPRITE_CIRCLE_EN
    localparam logic signed [27:0] RS = 28'(OBJ_SIZE / 2);
    logic signed [27:0] dx;
    logic signed [27:0] dy;
    logic signed [27:0] d2;
    assign dx       = $signed({16'd0, pix_col}) - $signed({16'd0, ex}) - RS;
    assign dy       = $signed({17'd0, pix_row}) - $signed({17'd0, ey}) - RS;
    assign d2       = dx * dx + dy * dy;
    assign hit_c[g] = in_sq & (d2 <= RS * RS);
`else
    assign hit_c[g] = in_sq;
`endif
  end

  always_comb begin
    sel = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (hit1[i]) sel = col1[i];
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      v1                 <= 1'b0;
      hit1               <= '0;
      out_valid          <= 1'b0;
      {red, green, blue} <= 12'h000;
      for (int i = 0; i < NUM_OBJ; i++) col1[i] <= 12'd0;
    end else begin
      v1                 <= pix_valid;
      hit1               <= hit_c;
      out_valid          <= v1;
      {red, green, blue} <= v1 ? sel : 12'h000;
      for (int i = 0; i < NUM_OBJ; i++) col1[i] <= eff_c[i];
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: random updates/pixels against a scene model,
// plus directed commit, priority, held-write, bad-index and reset cases.
module tb_sprite_renderer;

  localparam int          N  = 4;
  localparam int          S  = 32;
  localparam logic [11:0] BG = 12'h000;

  logic        clock_162 = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pix_col = '0;
  logic [10:0] pix_row = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [3:0]  upd_idx = '0;
  logic        upd_en = 1'b0;
  logic [11:0] upd_x = '0;
  logic [10:0] upd_y = '0;
  logic [11:0] upd_color = '0;
  logic [3:0]  red, green, blue;
  logic        out_valid;
  logic [15:0] frame_count;
  logic        upd_err;

  always #3 clock_162 = ~clock_162;

  sprite_renderer #(.NUM_OBJ(N), .OBJ_SIZE(S), .BG_COLOR(BG)) dut (
    .clock_162(clock_162), .rst(rst),
    .pix_col(pix_col), .pix_row(pix_row), .pix_valid(pix_valid),
    .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_en(upd_en), .upd_x(upd_x), .upd_y(upd_y), .upd_color(upd_color),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .frame_count(frame_count), .upd_err(upd_err)
  );

  typedef struct {
    bit          en;
    int          x;
    int          y;
    logic [11:0] c;
  } obj_t;

  obj_t        pend[N];
  obj_t        act[N];
  int          checks = 0;
  int          errors = 0;
  bit          m_run = 0;
  bit          m_err = 0;
  logic [15:0] m_fc = 0;
  bit          s1v = 0;
  logic [11:0] s1c = 0;
  bit          ov = 0;
  logic [11:0] oc = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scene as drawn: first enabled object covering the pixel, else background.
  function automatic logic [11:0] ref_color(int col, int row);
    for (int i = 0; i < N; i++)
      if (act[i].en && col >= act[i].x && col < act[i].x + S &&
          row >= act[i].y && row < act[i].y + S) begin
`ifdef SPRITE_CIRCLE_EN
        int r  = S / 2;
        int dx = col - act[i].x - r;
        int dy = row - act[i].y - r;
        if (dx * dx + dy * dy <= r * r) return act[i].c;
`else
        return act[i].c;
`endif
      end
    return BG;
  endfunction

  task automatic tick();
    bit rdy;
    #1;
    rdy = !rst && m_run && !frame_start;
    chk("upd_ready", 32'(upd_ready), 32'(rdy));
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pend[i] = '{0, 0, 0, 12'h0};
        act[i]  = '{0, 0, 0, 12'h0};
      end
      m_fc = 0; m_err = 0; s1v = 0; s1c = 0; ov = 0; oc = 0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < N; i++) act[i] = pend[i];
        m_fc++;
      end
      ov  = s1v;
      oc  = s1v ? s1c : 12'h000;
      s1v = pix_valid;
      s1c = ref_color(int'(pix_col), int'(pix_row));
      if (upd_valid && rdy) begin
        if (upd_idx < N)
          pend[upd_idx] = '{upd_en, int'(upd_x), int'(upd_y), upd_color};
        else
          m_err = 1;
      end
    end
    m_run = !rst;
    @(posedge clock_162);
    #1;
    chk("rgb", 32'({red, green, blue}), 32'(oc));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("upd_err", 32'(upd_err), 32'(m_err));
  endtask

  task automatic px(int c, int r);
    pix_col = 12'(c); pix_row = 11'(r); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic px_expect(string tag, int c, int r, logic [11:0] exp);
    px(c, r);
    tick();
    chk(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  task automatic wr(int idx, bit en, int x, int y, logic [11:0] c);
    upd_valid = 1'b1; upd_idx = 4'(idx); upd_en = en;
    upd_x = 12'(x); upd_y = 11'(y); upd_color = c;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

`ifdef SPRITE_CIRCLE_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    frame_start = 1'b1; pix_col = 0; pix_row = 0; pix_valid = 1'b1;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
    tick();
    chk("idle_bg", 32'({red, green, blue}), 32'(BG));
    chk("idle_fc", 32'(frame_count), 32'd1);

    wr(0, 1, 100, 50, 12'hF00);
    px_expect("pre_commit", 110, 60, BG);
    frame();
    px_expect("in_obj", 110, 60, 12'hF00);
    px_expect("right_edge", 131, 60, CIRC ? BG : 12'hF00);
    px_expect("past_edge", 132, 60, BG);

    wr(0, 1, 200, 200, 12'hF00);
    wr(1, 1, 200, 200, 12'h0F0);
    frame();
    px_expect("prio_low", 210, 210, 12'hF00);
    wr(0, 0, 200, 200, 12'hF00);
    frame();
    px_expect("prio_next", 210, 210, 12'h0F0);

    upd_valid = 1'b1; upd_idx = 4'd2; upd_en = 1'b1;
    upd_x = 12'd300; upd_y = 11'd300; upd_color = 12'h00F;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    upd_valid = 1'b0;
    px_expect("held_pending", 310, 310, BG);
    frame();
    px_expect("held_commit", 310, 310, 12'h00F);

    wr(15, 1, 0, 0, 12'hFFF);
    chk("err_set", 32'(upd_err), 32'd1);
    frame();
    px_expect("err_noslot", 5, 5, BG);

    for (int k = 0; k < 400; k++) begin
      frame_start = ($urandom_range(0, 9) == 0);
      upd_valid   = ($urandom_range(0, 2) == 0);
      upd_idx     = 4'($urandom_range(0, N - 1));
      upd_en      = ($urandom_range(0, 3) != 0);
      upd_x       = 12'($urandom_range(0, 250));
      upd_y       = 11'($urandom_range(0, 250));
      upd_color   = 12'($urandom);
      pix_valid   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 0) begin
        int o = $urandom_range(0, N - 1);
        pix_col = 12'(act[o].x + $urandom_range(0, S + 7) - 4 + 8);
        pix_row = 11'(act[o].y + $urandom_range(0, S + 7) - 4 + 8);
      end else begin
        pix_col = 12'($urandom_range(0, 300));
        pix_row = 11'($urandom_range(0, 300));
      end
      tick();
    end
    frame_start = 1'b0; upd_valid = 1'b0; pix_valid = 1'b0;

    frame_start = 1'b1;
    for (int k = 0; k < 65536; k++) tick();
    frame_start = 1'b0;
    tick();

    wr(0, 1, 0, 0, 12'hF00);
    frame();
    pix_col = 5; pix_row = 5; pix_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(upd_err), 32'd0);
    rst = 1'b0;
    tick(); tick();
    pix_valid = 1'b0;
    frame();
    px_expect("post_rst_bg", 5, 5, BG);
    wr(0, 1, 0, 0, 12'hF00);
    frame();
    px_expect("corner", 0, 0, CIRC ? BG : 12'hF00);
    px_expect("centre", 16, 16, 12'hF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
